// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings, handshake
// constants and the ALU op codes that select DIV/DIVU in EX.
package div_iter_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_t;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not underflow.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] diff;

   always_comb begin
      diff  = rem_in - {1'b0, divisor};
      q_bit = (rem_in >= {1'b0, divisor});
      // rem_in < 2*divisor, so either branch fits back into WIDTH bits
      rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];
   end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU returning {remainder, quotient}.
// Define DIV_ZERO_FLAG_EN to add the div_zero_o trap flag output.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic               busy_o,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic               div_zero_o
`endif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   dvd;
   logic [WIDTH-1:0]   dsr;
   logic               neg_q;
   logic               neg_r;
   logic [2*WIDTH-1:0] res;
`ifdef DIV_ZERO_FLAG_EN
   logic               is_zero;
`endif

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;
   logic [WIDTH-1:0]   next_dvd;
   logic [WIDTH-1:0]   fix_q;
   logic [WIDTH-1:0]   fix_r;

   // Signed operands are reduced to magnitudes; MIN maps to itself, which is
   // still the right unsigned magnitude.
   always_comb begin
      a_neg    = signed_div_i & opdata1_i[WIDTH-1];
      b_neg    = signed_div_i & opdata2_i[WIDTH-1];
      mag_a    = a_neg ? -opdata1_i : opdata1_i;
      mag_b    = b_neg ? -opdata2_i : opdata2_i;
      shifted  = {rem, dvd[WIDTH-1]};
      next_dvd = {dvd[WIDTH-2:0], step_q};
      fix_q    = neg_q ? -next_dvd : next_dvd;
      fix_r    = neg_r ? -step_rem : step_rem;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (shifted),
      .divisor (dsr),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   assign busy_o = (state == DivOn) || (state == DivByZero);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= DivFree;
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         res      <= '0;
         result_o <= '0;
         ready_o  <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
         is_zero    <= 1'b0;
         div_zero_o <= 1'b0;
`endif
      end else begin
         case (state)
            DivFree: begin
               result_o <= '0;
               ready_o  <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
               div_zero_o <= 1'b0;
`endif
               if (start_i == DivStart && !annul_i) begin
                  rem   <= '0;
                  dvd   <= mag_a;
                  dsr   <= mag_b;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  cnt   <= '0;
`ifdef DIV_ZERO_FLAG_EN
                  is_zero <= (opdata2_i == '0);
`endif
                  state <= (opdata2_i == '0) ? DivByZero : DivOn;
               end
            end
            DivByZero: begin
               res   <= '0;
               state <= DivEnd;
            end
            DivOn: begin
               if (annul_i) begin
                  state <= DivFree;
               end else begin
                  rem <= step_rem;
                  dvd <= next_dvd;
                  cnt <= cnt + 1'b1;
                  // Sign fix-up is folded into the final step's outputs.
                  if (cnt == LAST_STEP) begin
                     res   <= {fix_r, fix_q};
                     state <= DivEnd;
                  end
               end
            end
            DivEnd: begin
               if (start_i == DivStart) begin
                  result_o <= res;
                  ready_o  <= DivResultReady;
`ifdef DIV_ZERO_FLAG_EN
                  div_zero_o <= is_zero;
`endif
               end else begin
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
                  div_zero_o <= 1'b0;
`endif
                  state <= DivFree;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: stimulus pushes expected result and ready cycle,
// a negedge monitor checks each rising ready_o against the queue head.
module tb_div_iter;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           signed_div_i = 1'b0;
   logic [W-1:0]   opdata1_i = '0;
   logic [W-1:0]   opdata2_i = '0;
   logic           start_i = 1'b0;
   logic           annul_i = 1'b0;
   logic           busy_o;
   logic [2*W-1:0] result_o;
   logic           ready_o;
`ifdef DIV_ZERO_FLAG_EN
   logic           div_zero_o;
`endif

   div_iter #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .busy_o       (busy_o),
      .result_o     (result_o),
      .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
      ,
      .div_zero_o   (div_zero_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic        zero;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic prev_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: each rising ready_o consumes one scoreboard entry.
   always @(negedge clk) begin
      if (ready_o === 1'b1 && prev_rdy !== 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
         end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, result_o, e.res);
            check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
`ifdef DIV_ZERO_FLAG_EN
            check({e.name, "_divzero"}, 64'(div_zero_o), 64'(e.zero));
`endif
         end
      end
      prev_rdy = ready_o;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_op(input logic [63:0] r, input logic z, input string nm);
      exp_t x;
      x.res  = r;
      x.zero = z;
      x.due  = cyc + 1 + (z ? 2 : W + 1);
      x.name = nm;
      sb.push_back(x);
   endtask

   task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (ready_o !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      if (ready_o !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no ready expected ready within 60 cycles", nm);
         if (sb.size() > 0) void'(sb.pop_front());
      end
   endtask

   task automatic finish_op(input string nm);
      start_i = 1'b0;
      tick();
      check({nm, "_drop_ready"}, 64'(ready_o), 64'd0);
      check({nm, "_drop_result"}, result_o, 64'd0);
   endtask

   task automatic run(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [63:0] r, input logic z, input string nm);
      issue(sg, a, b);
      expect_op(r, z, nm);
      wait_ready(nm);
      finish_op(nm);
   endtask

   initial begin
      tick();
      tick();
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      rst = 1'b1;
      tick();

      // Unsigned 100/7 with start held past ready: result must stay stable.
      issue(1'b0, 32'd100, 32'd7);
      expect_op(64'h00000002_0000000E, 1'b0, "u100_7");
      wait_ready("u100_7");
      tick();
      tick();
      check("u100_7_hold_ready", 64'(ready_o), 64'd1);
      check("u100_7_hold_result", result_o, 64'h00000002_0000000E);
      finish_op("u100_7");

      run(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "s_m7_2");
      run(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, "s_7_m2");
      run(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0, "s_m100_m7");
      run(1'b0, 32'd5, 32'd0, 64'd0, 1'b1, "u5_0");
      run(1'b1, 32'hFFFFFFF9, 32'd0, 64'd0, 1'b1, "s_m7_0");
      run(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, "s_min_m1");
      run(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0, "u_max_1");

      // Operands changing mid-division must not affect the result.
      issue(1'b0, 32'd7, 32'd100);
      expect_op(64'h00000007_00000000, 1'b0, "u7_100");
      tick();
      opdata1_i = 32'hFFFFFFFF;
      opdata2_i = 32'd3;
      signed_div_i = 1'b1;
      wait_ready("u7_100");
      finish_op("u7_100");

      // Annul on the 10th ON cycle, then an immediate new request.
      issue(1'b0, 32'd100, 32'd7);
      tick();
      check("annul_busy_on", 64'(busy_o), 64'd1);
      repeat (9) tick();
      annul_i = 1'b1;
      tick();
      check("annul_busy", 64'(busy_o), 64'd0);
      check("annul_ready", 64'(ready_o), 64'd0);
      annul_i = 1'b0;
      expect_op(64'h00000002_0000000E, 1'b0, "annul_retry");
      wait_ready("annul_retry");
      finish_op("annul_retry");

      // Reset on the 5th ON cycle with start held high.
      issue(1'b0, 32'd1000, 32'd3);
      repeat (5) tick();
      rst = 1'b0;
      tick();
      check("rst_mid_busy", 64'(busy_o), 64'd0);
      check("rst_mid_ready", 64'(ready_o), 64'd0);
      check("rst_mid_result", result_o, 64'd0);
      rst = 1'b1;
      expect_op(64'h00000001_0000014D, 1'b0, "rst_retry");
      wait_ready("rst_retry");
      finish_op("rst_retry");

      repeat (3) tick();
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle restoring divider serving the EX stage for DIV/DIVU.
- Accepts a start request with latched operands and iterates one quotient bit per cycle.
- Returns {remainder, quotient} for the HI/LO write path.
- EX holds the pipeline stall request high while a request is accepted and ready_o is low.

Parameters:
- WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- signed_div_i  in  1  1 = signed division (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by EX until the result is consumed.
- annul_i  in  1  cancel the in-flight division (branch-delay flush or exception).
- busy_o  out  1  high in states ON and BYZERO.
- result_o  out  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst=0 at an edge): state becomes FREE; result_o, ready_o, busy_o and the counter all go to 0. This applies even mid-operation.
- FREE:
  - start_i=1 and annul_i=0: latch operands.
  - If divisor == 0, go to BYZERO; otherwise go to ON with counter=0.
  - Any other input combination: stay in FREE with ready_o=0 and result_o=0.
- Signed mode operand handling at latch time:
  - A negative dividend or divisor is replaced by its two's-complement magnitude.
  - The original signs are recorded.
- ON:
  - Each cycle performs one restoring step:
    - shift {partial remainder, dividend} left by 1;
    - trial-subtract the divisor magnitude from the top WIDTH+1 bits;
    - if the result is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - The counter increments each step. After WIDTH steps, go to END.
  - annul_i=1 in any ON cycle: go to FREE at the next edge. ready_o stays 0 and no result is produced.
  - Changes on opdata*_i while in ON are ignored.
- Sign fix-up on the transition into END, signed mode only:
  - the quotient is negated if the operand signs differed;
  - the remainder is negated if the dividend was negative.
  - All arithmetic is modulo 2^WIDTH. MIN/-1 therefore yields quotient = MIN and remainder = 0, with no exception.
- BYZERO: go to END with quotient=0 and remainder=0 (one cycle).
- END:
  - ready_o=1 and result_o holds the result.
  - Stay in END while start_i=1.
  - When start_i=0, go to FREE; ready_o and result_o return to 0 at that edge.
  - annul_i in END is ignored, since the result is already committed.
- Latency, with start sampled at edge k:
  - normal division: ready_o is high after edge k+WIDTH+1;
  - divide by zero: ready_o is high after edge k+2.
- A new start_i is accepted only in FREE. Back-to-back operations require one FREE cycle between them.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - adds output port div_zero_o (1 bit, reset 0);
  - div_zero_o=1 exactly while ready_o=1 for a request whose divisor was 0;
  - the exception logic uses it to raise a trap.
- Undefined: the port is absent. Divide-by-zero silently returns zeros, as in the base behaviour.

Decomposition:
- Shared package (the existing define file), holding:
  - state encodings: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11;
  - DivResultReady/DivResultNotReady and DivStart/DivStop constants;
  - the new aluop codes EXE_DIV_OP and EXE_DIVU_OP.
- Sub-module div_step: purely combinational single restoring iteration (WIDTH-parametrised). Inputs are the partial remainder and divisor; outputs are the next remainder and the quotient bit. Instantiated once.

Test Plan (WIDTH=32):
- Unsigned 100/7, start held high: ready_o rises 33 cycles after start; result_o = 0x00000002_0000000E. Drop start_i: ready_o=0 and result_o=0 on the next edge.
- Signed -7/2 (0xFFFFFFF9/0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD, i.e. remainder -1, quotient -3. Also 7/-2 gives result_o = 0x00000001_FFFFFFFD.
- Divide by zero, 5/0:
  - ready_o rises 2 cycles after start and result_o = 0;
  - with DIV_ZERO_FLAG_EN defined, div_zero_o=1 alongside ready_o.
- Signed 0x80000000/0xFFFFFFFF: result_o = 0x00000000_80000000 with no hang. Unsigned 0xFFFFFFFF/1 gives quotient 0xFFFFFFFF and remainder 0.
- Annul on the 10th ON cycle: block returns to FREE next edge and ready_o never rises. An immediate new request 100/7 still yields 0x00000002_0000000E.
- rst=0 asserted on the 5th ON cycle:
  - after that edge busy_o, ready_o and result_o are all 0;
  - with start_i held high and rst back at 1, the division restarts from FREE and completes correctly.
